// File: rtl/ibex_pkg.sv
// Shared types and constants for the IF-stage fetch request path.
package ibex_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_GNT = 1'b1
  } fetch_req_state_e;

  localparam logic [31:0] FETCH_WORD_BYTES = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/ibex_fetch_outstanding_q.sv
// In-order queue of outstanding bus requests; each slot remembers whether
// its response must be thrown away because a branch overtook it.
module ibex_fetch_outstanding_q #(
  parameter int NUM_REQS = 2,
  parameter int CNT_W    = $clog2(NUM_REQS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alloc_i,
  input  logic             alloc_discard_i,
  input  logic             retire_i,
  input  logic             discard_all_i,
  output logic             head_discard_o,
  output logic [CNT_W-1:0] count_o
);

  logic [NUM_REQS-1:0] disc_q, disc_d;
  logic [CNT_W-1:0]    count_q, count_d, cnt_ret;

  // Retire shifts the head out first, so a same-cycle allocation lands
  // directly behind the surviving entries and the count is unchanged.
  always_comb begin
    cnt_ret = count_q - CNT_W'(retire_i);
    disc_d  = retire_i ? (disc_q >> 1) : disc_q;
    count_d = cnt_ret;
    if (discard_all_i) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (i < int'(cnt_ret)) disc_d[i] = 1'b1;
      end
    end
    if (alloc_i && (int'(cnt_ret) < NUM_REQS)) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (i == int'(cnt_ret)) disc_d[i] = alloc_discard_i;
      end
      count_d = cnt_ret + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      disc_q  <= '0;
    end else begin
      count_q <= count_d;
      disc_q  <= disc_d;
    end
  end

  assign head_discard_o = disc_q[0];
  assign count_o        = count_q;

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Fetch request controller: issues word-aligned instruction bus requests and
// pushes in-order responses into the fetch FIFO, dropping ones a branch made stale.
module ibex_fetch_req_ctrl
  import ibex_pkg::*;
#(
  parameter int NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(NUM_REQS + 1);
  localparam int SUM_W = CNT_W + 1;

  fetch_req_state_e state_q, state_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      held_addr_q, held_addr_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      branch_target;
  logic [SUM_W-1:0] busy_count;
  logic [CNT_W-1:0] out_count;
  logic             head_discard;
  logic             can_issue;
  logic             req_gnt;
  logic             alloc_discard;

  assign branch_target = word_align(branch_addr_i);

  // FIFO slots already taken plus responses still in flight bound new requests.
  always_comb begin
    busy_count = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      busy_count = busy_count + SUM_W'(fifo_busy_i[i]);
    end
  end

  assign can_issue = (busy_count + SUM_W'(out_count)) < SUM_W'(NUM_REQS);

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    held_addr_d   = held_addr_q;
    redirect_d    = redirect_q;
    instr_req_o   = 1'b0;
    instr_addr_o  = fetch_addr_q;
    alloc_discard = 1'b0;
    case (state_q)
      IDLE: begin
        instr_req_o  = (req_i | branch_i) & can_issue;
        instr_addr_o = branch_i ? branch_target : fetch_addr_q;
        if (instr_req_o) begin
          if (instr_gnt_i) begin
            fetch_addr_d = instr_addr_o + FETCH_WORD_BYTES;
          end else begin
            held_addr_d = instr_addr_o;
            state_d     = WAIT_GNT;
          end
        end else if (branch_i) begin
          fetch_addr_d = branch_target;
        end
      end
      WAIT_GNT: begin
        // The bus protocol forbids retracting or changing a pending request,
        // so a branch only redirects where fetching resumes after the grant.
        instr_req_o   = 1'b1;
        instr_addr_o  = held_addr_q;
        alloc_discard = redirect_q | branch_i;
        if (branch_i) begin
          fetch_addr_d = branch_target;
          redirect_d   = 1'b1;
        end
        if (instr_gnt_i) begin
          state_d    = IDLE;
          redirect_d = 1'b0;
          if (!alloc_discard) fetch_addr_d = held_addr_q + FETCH_WORD_BYTES;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_gnt = instr_req_o & instr_gnt_i;

  ibex_fetch_outstanding_q #(
    .NUM_REQS (NUM_REQS),
    .CNT_W    (CNT_W)
  ) u_outstanding (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .alloc_i         (req_gnt),
    .alloc_discard_i (alloc_discard),
    .retire_i        (instr_rvalid_i),
    .discard_all_i   (branch_i),
    .head_discard_o  (head_discard),
    .count_o         (out_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      held_addr_q  <= '0;
      redirect_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      held_addr_q  <= held_addr_d;
      redirect_q   <= redirect_d;
    end
  end

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = branch_i ? branch_addr_i : 32'h0;
  assign fifo_valid_o = instr_rvalid_i & ~head_discard & ~branch_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = instr_req_o | (out_count != '0);

  a_rvalid_empty : assert property (@(posedge clk_i) disable iff (rst_i)
    instr_rvalid_i |-> (out_count != '0));
  a_gnt_no_req : assert property (@(posedge clk_i) disable iff (rst_i)
    instr_gnt_i |-> instr_req_o);
  a_addr_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (instr_req_o && !instr_gnt_i) |=> (instr_addr_o == $past(instr_addr_o)));
  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    out_count <= CNT_W'(NUM_REQS));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Bench for ibex_fetch_req_ctrl: directed scenarios plus random traffic
// checked against a queue-based behavioural model.
module tb_ibex_fetch_req_ctrl;

  // Three slots so a branch with two requests in flight can still issue.
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0, branch = 1'b0, gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
  logic [31:0]   baddr = '0, rdata = '0;
  logic [N-1:0]  fbusy = '0;
  logic          fifo_clear_o, fifo_valid_o, fifo_err_o, instr_req_o, busy_o;
  logic [31:0]   fifo_addr_o, fifo_rdata_o, instr_addr_o;

  ibex_fetch_req_ctrl #(.NUM_REQS(N)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .branch_i       (branch),
    .branch_addr_i  (baddr),
    .fifo_busy_i    (fbusy),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_err_o     (fifo_err_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (gnt),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (rvalid),
    .instr_rdata_i  (rdata),
    .instr_err_i    (err),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  wire [100:0] obs = {instr_req_o, instr_addr_o, fifo_clear_o, fifo_addr_o,
                      fifo_valid_o, fifo_rdata_o, fifo_err_o, busy_o};

  // Model: queue of "drop this response" flags plus the next fetch address
  // and an optional request the bus has not yet accepted.
  bit          m_q[$];
  logic [31:0] m_fetch = '0, m_paddr = '0;
  bit          m_pend = 0, m_redir = 0;
  logic        e_req, e_valid;
  logic [31:0] e_addr;
  logic [100:0] expv;

  task automatic model_predict();
    logic [31:0] tgt;
    bit head_drop;
    tgt = baddr & ~32'h3;
    head_drop = (m_q.size() > 0) ? m_q[0] : 1'b0;
    if (m_pend) begin
      e_req  = 1'b1;
      e_addr = m_paddr;
    end else begin
      e_req  = (req || branch) && (($countones(fbusy) + m_q.size()) < N);
      e_addr = branch ? tgt : m_fetch;
    end
    e_valid = rvalid && (m_q.size() > 0) && !head_drop && !branch;
    expv = {e_req, e_addr, branch, (branch ? baddr : 32'h0), e_valid, rdata, err,
            (e_req || (m_q.size() != 0))};
  endtask

  task automatic model_commit();
    logic [31:0] tgt;
    bit drop;
    tgt = baddr & ~32'h3;
    if (rst) begin
      m_q.delete();
      m_fetch = '0; m_paddr = '0; m_pend = 0; m_redir = 0;
      return;
    end
    if (rvalid && m_q.size() > 0) void'(m_q.pop_front());
    if (branch) foreach (m_q[i]) m_q[i] = 1'b1;
    if (m_pend) begin
      drop = m_redir || branch;
      if (branch) begin m_redir = 1; m_fetch = tgt; end
      if (gnt) begin
        m_q.push_back(drop);
        if (!drop) m_fetch = m_paddr + 32'd4;
        m_pend = 0; m_redir = 0;
      end
    end else if (e_req) begin
      if (gnt) begin m_q.push_back(1'b0); m_fetch = e_addr + 32'd4; end
      else begin m_pend = 1; m_paddr = e_addr; end
    end else if (branch) begin
      m_fetch = tgt;
    end
  endtask

  task automatic set_in(input bit r, input bit b, input logic [31:0] ba, input logic [N-1:0] fb,
                        input bit g, input bit rv, input logic [31:0] rd, input bit e);
    req = r; branch = b; baddr = ba; fbusy = fb; gnt = g; rvalid = rv; rdata = rd; err = e;
    #1;
    model_predict();
  endtask

  task automatic tick();
    model_predict();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    set_in(0, 0, 32'h0, '0, 0, 0, 32'h0, 0);
    tick(); tick();
    rst = 0;
    set_in(0, 0, 32'h0, '0, 0, 0, 32'h0, 0);
    n_total++;
    if (obs !== 101'd0) $display("FAIL reset_outputs got=%h exp=0", obs); else n_pass++;
    n_total++;
    if (dut.u_outstanding.count_o !== 2'd0)
      $display("FAIL reset_count got=%0d exp=0", dut.u_outstanding.count_o);
    else n_pass++;
  endtask

  task automatic test_straight_line();
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      rd = 32'hD000_0000 + 32'(i);
      set_in(i < 3, i == 0, 32'h100, '0, i < 3, i > 0, rd, 0);
      if (i < 3) begin
        n_total++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h100 + 32'(4 * i)})
          $display("FAIL sl_addr cyc=%0d got=%b/%h exp=1/%h", i, instr_req_o, instr_addr_o, 32'h100 + 32'(4 * i));
        else n_pass++;
      end
      if (i == 0) begin
        n_total++;
        if ({fifo_clear_o, fifo_addr_o} !== {1'b1, 32'h100})
          $display("FAIL sl_clear got=%b/%h exp=1/00000100", fifo_clear_o, fifo_addr_o);
        else n_pass++;
      end else begin
        n_total++;
        if ({fifo_valid_o, fifo_rdata_o} !== {1'b1, rd})
          $display("FAIL sl_push cyc=%0d got=%b/%h exp=1/%h", i, fifo_valid_o, fifo_rdata_o, rd);
        else n_pass++;
      end
      n_total++;
      if (obs !== expv) $display("FAIL sl_model cyc=%0d got=%h exp=%h", i, obs, expv); else n_pass++;
      tick();
    end
    set_in(0, 0, 32'h0, '0, 0, 0, 32'h0, 0);
    n_total++;
    if (busy_o !== 1'b0) $display("FAIL sl_idle got=%b exp=0", busy_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    // Full FIFO, then FIFO+outstanding at the limit, then one below it.
    set_in(1, 0, 32'h0, 3'b111, 0, 0, 32'h0, 0);
    n_total++;
    if (instr_req_o !== 1'b0) $display("FAIL bp_full got=%b exp=0", instr_req_o); else n_pass++;
    tick();
    set_in(1, 0, 32'h0, '0, 1, 0, 32'h0, 0);
    n_total++;
    if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h10C})
      $display("FAIL bp_issue got=%b/%h exp=1/0000010c", instr_req_o, instr_addr_o);
    else n_pass++;
    tick();
    set_in(1, 0, 32'h0, 3'b011, 0, 0, 32'h0, 0);
    n_total++;
    if (instr_req_o !== 1'b0) $display("FAIL bp_limit got=%b exp=0", instr_req_o); else n_pass++;
    tick();
    set_in(1, 0, 32'h0, 3'b001, 1, 0, 32'h0, 0);
    n_total++;
    if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h110})
      $display("FAIL bp_below got=%b/%h exp=1/00000110", instr_req_o, instr_addr_o);
    else n_pass++;
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 32'h0, '0, 0, 1, 32'hB000_0000 + 32'(i), 0);
      n_total++;
      if (obs !== expv) $display("FAIL bp_drain cyc=%0d got=%h exp=%h", i, obs, expv); else n_pass++;
      tick();
    end
  endtask

  task automatic test_grant_stall_branch();
    logic [31:0] rd;
    for (int c = 0; c < 6; c++) begin
      rd = 32'h5A00_0000 + 32'(c);
      set_in(c < 5, c < 2, (c == 0) ? 32'h200 : 32'h402, '0, (c >= 3) && (c < 5), c >= 4, rd, 0);
      if (c < 4) begin
        n_total++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h200})
          $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/00000200", c, instr_req_o, instr_addr_o);
        else n_pass++;
      end else if (c == 4) begin
        n_total++;
        if ({instr_req_o, instr_addr_o, fifo_valid_o} !== {1'b1, 32'h400, 1'b0})
          $display("FAIL stall_redir got=%b/%h/%b exp=1/00000400/0", instr_req_o, instr_addr_o, fifo_valid_o);
        else n_pass++;
      end else begin
        n_total++;
        if ({fifo_valid_o, fifo_rdata_o} !== {1'b1, rd})
          $display("FAIL stall_push got=%b/%h exp=1/%h", fifo_valid_o, fifo_rdata_o, rd);
        else n_pass++;
      end
      n_total++;
      if (obs !== expv) $display("FAIL stall_model cyc=%0d got=%h exp=%h", c, obs, expv); else n_pass++;
      tick();
    end
  endtask

  task automatic test_branch_outstanding();
    logic [31:0] rd, ea;
    for (int c = 0; c < 6; c++) begin
      rd = 32'h3300_0000 + 32'(c);
      ea = (c == 0) ? 32'h300 : ((c == 1) ? 32'h304 : 32'h500);
      set_in(c < 3, (c == 0) || (c == 2), (c == 0) ? 32'h300 : 32'h500, '0, c < 3, c >= 3, rd, 0);
      if (c < 3) begin
        n_total++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, ea})
          $display("FAIL bo_addr cyc=%0d got=%b/%h exp=1/%h", c, instr_req_o, instr_addr_o, ea);
        else n_pass++;
      end else begin
        n_total++;
        if (fifo_valid_o !== (c == 5))
          $display("FAIL bo_valid cyc=%0d got=%b exp=%b", c, fifo_valid_o, c == 5);
        else n_pass++;
      end
      n_total++;
      if (obs !== expv) $display("FAIL bo_model cyc=%0d got=%h exp=%h", c, obs, expv); else n_pass++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    // Grant and response in the same cycle while two are outstanding.
    set_in(1, 1, 32'h600, '0, 1, 0, 32'h0, 0); tick();
    set_in(1, 0, 32'h0, '0, 1, 0, 32'h0, 0); tick();
    set_in(1, 0, 32'h0, '0, 1, 1, 32'h6666_0600, 0);
    n_total++;
    if ({instr_req_o, instr_addr_o, fifo_valid_o, fifo_rdata_o} !== {1'b1, 32'h608, 1'b1, 32'h6666_0600})
      $display("FAIL b2b_same got=%b/%h/%b/%h exp=1/00000608/1/66660600",
               instr_req_o, instr_addr_o, fifo_valid_o, fifo_rdata_o);
    else n_pass++;
    tick();
    set_in(1, 0, 32'h0, 3'b001, 0, 0, 32'h0, 0);
    n_total++;
    if (dut.u_outstanding.count_o !== 2'd2)
      $display("FAIL b2b_count got=%0d exp=2", dut.u_outstanding.count_o);
    else n_pass++;
    n_total++;
    if (instr_req_o !== 1'b0) $display("FAIL b2b_block got=%b exp=0", instr_req_o); else n_pass++;
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 32'h0, '0, 0, 1, 32'h6666_0604 + 32'(4 * i), 0);
      n_total++;
      if (obs !== expv) $display("FAIL b2b_drain cyc=%0d got=%h exp=%h", i, obs, expv); else n_pass++;
      tick();
    end
  endtask

  task automatic test_error_reset();
    set_in(1, 1, 32'h700, '0, 1, 0, 32'h0, 0); tick();
    set_in(1, 0, 32'h0, '0, 1, 1, 32'hEEEE_0700, 1);
    n_total++;
    if ({fifo_valid_o, fifo_err_o} !== 2'b11)
      $display("FAIL err_pass got=%b/%b exp=1/1", fifo_valid_o, fifo_err_o);
    else n_pass++;
    tick();
    rst = 1;
    set_in(1, 0, 32'h0, '0, 1, 0, 32'h0, 0);
    tick();
    rst = 0;
    set_in(0, 0, 32'h0, '0, 0, 0, 32'h0, 0);
    n_total++;
    if ({instr_req_o, busy_o} !== 2'b00)
      $display("FAIL rst_mid got=%b/%b exp=0/0", instr_req_o, busy_o);
    else n_pass++;
    n_total++;
    if (dut.u_outstanding.count_o !== 2'd0)
      $display("FAIL rst_queue got=%0d exp=0", dut.u_outstanding.count_o);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] ba;
    logic [N-1:0] fb;
    for (int c = 0; c < 400; c++) begin
      ba = $urandom & ~32'h1;
      fb = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, ba, fb, 0,
             (m_q.size() > 0) && ($urandom_range(0, 1) == 1), $urandom, $urandom_range(0, 7) == 0);
      if (e_req && ($urandom_range(0, 2) != 0)) begin gnt = 1'b1; #1; end
      n_total++;
      if (obs !== expv) $display("FAIL rand cyc=%0d got=%h exp=%h", c, obs, expv); else n_pass++;
      tick();
    end
    for (int c = 0; c < 20 && (m_q.size() > 0 || m_pend); c++) begin
      set_in(0, 0, 32'h0, '0, 0, m_q.size() > 0, $urandom, 0);
      if (e_req) begin gnt = 1'b1; #1; end
      tick();
    end
    set_in(0, 0, 32'h0, '0, 0, 0, 32'h0, 0);
    n_total++;
    if (busy_o !== 1'b0 || m_q.size() != 0)
      $display("FAIL rand_drain got=%b exp=0 model_q=%0d", busy_o, m_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_backpressure();
    test_grant_stall_branch();
    test_branch_outstanding();
    test_back_to_back();
    test_error_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
